// File: rtl/keypad_scan_debounce_if.sv
// Signal bundle between raw keypad pins / control logic and keypad_scan_debounce.
// The master drives key levels and selection; the slave (the scanner) drives the results.
interface keypad_if #(
  parameter int N_KEYS = 12,
  parameter int SEL_W  = 4
);
  logic [N_KEYS-1:0] i_key_in;
  logic              i_mode;
  logic [SEL_W-1:0]  i_sel;
  logic              o_key_out;
  logic [SEL_W-1:0]  o_key_code;
  logic              o_press_vld;
  logic              o_release;
  logic              o_busy;
  logic              o_sel_err;

  modport master (
    output i_key_in, i_mode, i_sel,
    input  o_key_out, o_key_code, o_press_vld, o_release, o_busy, o_sel_err
  );

  modport slave (
    input  i_key_in, i_mode, i_sel,
    output o_key_out, o_key_code, o_press_vld, o_release, o_busy, o_sel_err
  );
endinterface

// File: rtl/keypad_scan_debounce.sv
// Keypad front end: per-key synchroniser and debounce, then either a manual selector
// or a round-robin scan FSM that reports one held key with press/release pulses.
module keypad_scan_debounce #(
  parameter int N_KEYS     = 12,
  parameter int SEL_W      = 4,
  parameter int DEB_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  keypad_if.slave kp
);

  localparam int               N_SLOTS  = 1 << SEL_W;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_KEY = SEL_W'(N_KEYS - 1);

  typedef enum logic {ST_SCAN, ST_HOLD} state_t;

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] r_stable;
  logic [N_KEYS-1:0] r_stable_q;
  logic [CNT_W-1:0]  r_cnt [N_KEYS];

  state_t            r_state;
  logic              r_mode_q;
  logic [SEL_W-1:0]  r_idx;
  logic              r_key_out;
  logic [SEL_W-1:0]  r_key_code;
  logic              r_press;
  logic              r_release;
  logic              r_busy;
  logic              r_sel_err;

  // Synchroniser and debounce. A key's counter only runs while its synchronised level
  // disagrees with the accepted level, so a short glitch clears it before it can flip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_q <= '0;
      // NOTE: the counter array is small and every entry must start at 0, so it is reset
      // element by element rather than left to power-up values like a RAM.
      for (int k = 0; k < N_KEYS; k++) r_cnt[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments let r_sync2 take the old r_sync1, forming a real
      // two-stage synchroniser instead of collapsing into one flop.
      r_sync1    <= kp.i_key_in;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      for (int k = 0; k < N_KEYS; k++) begin
        if (r_sync2[k] == r_stable[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == DEB_LAST) begin
          r_stable[k] <= ~r_stable[k];
          r_cnt[k]    <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Zero-extend to the full code space so any selector value indexes safely.
  logic [N_SLOTS-1:0] w_stable_ext;
  logic [N_SLOTS-1:0] w_prev_ext;
  logic               w_sel_ok;
  logic               w_sel_cur;
  logic               w_sel_prev;
  logic               w_idx_hit;
  logic               w_hold_hit;
  logic [SEL_W-1:0]   w_idx_next;
  logic [SEL_W-1:0]   w_code_next;

  assign w_stable_ext = N_SLOTS'(r_stable);
  assign w_prev_ext   = N_SLOTS'(r_stable_q);
  assign w_sel_ok     = (kp.i_sel <= LAST_KEY);
  assign w_sel_cur    = w_stable_ext[kp.i_sel];
  assign w_sel_prev   = w_prev_ext[kp.i_sel];
  assign w_idx_hit    = w_stable_ext[r_idx];
  assign w_hold_hit   = w_stable_ext[r_key_code];
  assign w_idx_next   = (r_idx == LAST_KEY) ? '0 : r_idx + 1'b1;
  assign w_code_next  = (r_key_code == LAST_KEY) ? '0 : r_key_code + 1'b1;

  // Reporting: mode-change recovery, manual selector, or scan FSM. All outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_SCAN;
      r_mode_q   <= 1'b0;
      r_idx      <= '0;
      r_key_out  <= 1'b0;
      r_key_code <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_busy     <= 1'b0;
      r_sel_err  <= 1'b0;
    end else begin
      r_mode_q  <= kp.i_mode;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (kp.i_mode != r_mode_q) begin
        r_key_out <= 1'b0;
        r_busy    <= 1'b0;
        r_sel_err <= 1'b0;
        r_state   <= ST_SCAN;
        r_idx     <= '0;
      end else if (!kp.i_mode) begin
        r_key_code <= kp.i_sel;
        r_busy     <= 1'b0;
        r_sel_err  <= ~w_sel_ok;
        if (w_sel_ok) begin
          r_key_out <= w_sel_cur;
          r_press   <= w_sel_cur & ~w_sel_prev;
          r_release <= ~w_sel_cur & w_sel_prev;
        end else begin
          r_key_out <= 1'b0;
        end
      end else begin
        r_sel_err <= 1'b0;
        case (r_state)
          ST_SCAN: begin
            if (w_idx_hit) begin
              r_key_code <= r_idx;
              r_press    <= 1'b1;
              r_key_out  <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= ST_HOLD;
            end else begin
              r_idx <= w_idx_next;
            end
          end
          ST_HOLD: begin
            // Resume just past the released key so every key gets its turn.
            if (!w_hold_hit) begin
              r_release <= 1'b1;
              r_key_out <= 1'b0;
              r_busy    <= 1'b0;
              r_idx     <= w_code_next;
              r_state   <= ST_SCAN;
            end
          end
          default: r_state <= ST_SCAN;
        endcase
      end
    end
  end

  assign kp.o_key_out   = r_key_out;
  assign kp.o_key_code  = r_key_code;
  assign kp.o_press_vld = r_press;
  assign kp.o_release   = r_release;
  assign kp.o_busy      = r_busy;
  assign kp.o_sel_err   = r_sel_err;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with DEB_CYCLES=4, N_KEYS=12.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_keypad_scan_debounce;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  keypad_if #(.N_KEYS(12), .SEL_W(4)) kp ();

  keypad_scan_debounce #(
    .N_KEYS(12), .SEL_W(4), .DEB_CYCLES(4), .CNT_W(4)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits for a press (want_press=1) or release pulse; cyc=-1 if none within max_cyc.
  // other counts pulses of the opposite kind seen while waiting.
  task automatic wait_pulse(input bit want_press, input int max_cyc,
                            output int cyc, output int other);
    cyc   = -1;
    other = 0;
    for (int i = 0; i < max_cyc && cyc < 0; i++) begin
      tick();
      if (want_press ? kp.o_release : kp.o_press_vld) other++;
      if (want_press ? kp.o_press_vld : kp.o_release) cyc = i;
    end
  endtask

  function automatic logic [8:0] out_vec();
    return {kp.o_key_out, kp.o_key_code, kp.o_press_vld, kp.o_release, kp.o_busy, kp.o_sel_err};
  endfunction

  task automatic test_reset();
    rst_n       = 1'b0;
    kp.i_key_in = '0;
    kp.i_mode   = 1'b0;
    kp.i_sel    = 4'd0;
    #1;
    n_checks++;
    if (out_vec() !== 9'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", out_vec(), 9'd0);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (out_vec() !== 9'd0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected %b", out_vec(), 9'd0);
    end
  endtask

  task automatic test_manual_press();
    int pc, np, nr, rc;
    kp.i_mode = 1'b0;
    kp.i_sel  = 4'd3;
    repeat (2) tick();
    kp.i_key_in[3] = 1'b1;
    pc = -1; np = 0; nr = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (kp.o_press_vld) begin np++; if (pc < 0) pc = i; end
      if (kp.o_release) nr++;
    end
    n_checks++;
    if (np !== 1) begin n_fail++; $display("FAIL manual_press_count: got %0d expected 1", np); end
    n_checks++;
    if (pc !== 6) begin n_fail++; $display("FAIL manual_press_latency: got %0d expected 6", pc); end
    n_checks++;
    if (nr !== 0) begin n_fail++; $display("FAIL manual_no_release: got %0d expected 0", nr); end
    n_checks++;
    if (kp.o_key_out !== 1'b1) begin n_fail++; $display("FAIL manual_key_out_high: got %b expected 1", kp.o_key_out); end
    n_checks++;
    if (kp.o_key_code !== 4'd3) begin n_fail++; $display("FAIL manual_key_code: got %0d expected 3", kp.o_key_code); end
    kp.i_key_in[3] = 1'b0;
    rc = -1; np = 0; nr = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (kp.o_release) begin nr++; if (rc < 0) rc = i; end
      if (kp.o_press_vld) np++;
    end
    n_checks++;
    if (nr !== 1) begin n_fail++; $display("FAIL manual_release_count: got %0d expected 1", nr); end
    n_checks++;
    if (rc !== 6) begin n_fail++; $display("FAIL manual_release_latency: got %0d expected 6", rc); end
    n_checks++;
    if (np !== 0) begin n_fail++; $display("FAIL manual_no_press_on_drop: got %0d expected 0", np); end
    n_checks++;
    if (kp.o_key_out !== 1'b0) begin n_fail++; $display("FAIL manual_key_out_low: got %b expected 0", kp.o_key_out); end
  endtask

  task automatic test_glitch();
    int np, nr, nh;
    kp.i_sel = 4'd6;
    tick();
    kp.i_key_in[6] = 1'b1;
    np = 0; nr = 0; nh = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) kp.i_key_in[6] = 1'b0;
      tick();
      if (kp.o_press_vld) np++;
      if (kp.o_release) nr++;
      if (kp.o_key_out) nh++;
    end
    n_checks++;
    if ((np + nr) !== 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d expected 0", np + nr); end
    n_checks++;
    if (nh !== 0) begin n_fail++; $display("FAIL glitch_key_out: got %0d high cycles expected 0", nh); end
  endtask

  task automatic test_sel_err();
    int np, cyc, other;
    kp.i_sel       = 4'b1100;
    kp.i_key_in[0] = 1'b1;
    np = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (kp.o_press_vld || kp.o_release) np++;
    end
    n_checks++;
    if (kp.o_sel_err !== 1'b1) begin n_fail++; $display("FAIL sel_err_set: got %b expected 1", kp.o_sel_err); end
    n_checks++;
    if (kp.o_key_out !== 1'b0) begin n_fail++; $display("FAIL sel_err_key_out: got %b expected 0", kp.o_key_out); end
    n_checks++;
    if (kp.o_key_code !== 4'd12) begin n_fail++; $display("FAIL sel_err_key_code: got %0d expected 12", kp.o_key_code); end
    n_checks++;
    if (np !== 0) begin n_fail++; $display("FAIL sel_err_pulses: got %0d expected 0", np); end
    kp.i_sel = 4'b0000;
    tick();
    n_checks++;
    if (kp.o_sel_err !== 1'b0) begin n_fail++; $display("FAIL sel_err_clear: got %b expected 0", kp.o_sel_err); end
    n_checks++;
    if (kp.o_key_out !== 1'b1) begin n_fail++; $display("FAIL sel0_key_out: got %b expected 1", kp.o_key_out); end
    n_checks++;
    if (kp.o_press_vld !== 1'b0) begin n_fail++; $display("FAIL sel_change_no_pulse: got %b expected 0", kp.o_press_vld); end
    kp.i_key_in[0] = 1'b0;
    wait_pulse(1'b0, 12, cyc, other);
    n_checks++;
    if (cyc !== 6) begin n_fail++; $display("FAIL sel0_release: got cycle %0d expected 6", cyc); end
  endtask

  task automatic test_scan_priority();
    int cyc, other, np;
    kp.i_key_in[3] = 1'b1;
    kp.i_key_in[6] = 1'b1;
    repeat (10) tick();
    kp.i_mode = 1'b1;
    wait_pulse(1'b1, 20, cyc, other);
    n_checks++;
    if (cyc !== 4) begin n_fail++; $display("FAIL scan_first_press_cycle: got %0d expected 4", cyc); end
    n_checks++;
    if (kp.o_key_code !== 4'd3) begin n_fail++; $display("FAIL scan_first_code: got %0d expected 3", kp.o_key_code); end
    n_checks++;
    if ({kp.o_busy, kp.o_key_out} !== 2'b11) begin n_fail++; $display("FAIL scan_busy_keyout: got %b expected 11", {kp.o_busy, kp.o_key_out}); end
    np = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (kp.o_press_vld) np++;
    end
    n_checks++;
    if (np !== 0) begin n_fail++; $display("FAIL scan_hold_ignores_other: got %0d presses expected 0", np); end
    kp.i_key_in[3] = 1'b0;
    wait_pulse(1'b0, 20, cyc, other);
    n_checks++;
    if (cyc !== 6) begin n_fail++; $display("FAIL scan_release3_cycle: got %0d expected 6", cyc); end
    n_checks++;
    if (kp.o_busy !== 1'b0) begin n_fail++; $display("FAIL scan_release_busy: got %b expected 0", kp.o_busy); end
    wait_pulse(1'b1, 12, cyc, other);
    n_checks++;
    if (cyc !== 2) begin n_fail++; $display("FAIL scan_next_press_cycle: got %0d expected 2", cyc); end
    n_checks++;
    if (kp.o_key_code !== 4'd6) begin n_fail++; $display("FAIL scan_next_code: got %0d expected 6", kp.o_key_code); end
    kp.i_key_in[6] = 1'b0;
    wait_pulse(1'b0, 20, cyc, other);
    n_checks++;
    if (cyc < 0) begin n_fail++; $display("FAIL scan_release6: got %0d expected a release", cyc); end
  endtask

  task automatic test_scan_wrap();
    int cyc, other, np;
    kp.i_key_in[11] = 1'b1;
    wait_pulse(1'b1, 30, cyc, other);
    n_checks++;
    if (cyc < 0 || kp.o_key_code !== 4'd11) begin
      n_fail++; $display("FAIL wrap_press11: got cycle %0d code %0d expected code 11", cyc, kp.o_key_code);
    end
    kp.i_key_in[0] = 1'b1;
    np = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (kp.o_press_vld) np++;
    end
    n_checks++;
    if (np !== 0 || kp.o_key_code !== 4'd11 || kp.o_busy !== 1'b1) begin
      n_fail++; $display("FAIL wrap_hold11: got presses %0d code %0d busy %b expected 0 11 1", np, kp.o_key_code, kp.o_busy);
    end
    kp.i_key_in[11] = 1'b0;
    wait_pulse(1'b0, 20, cyc, other);
    n_checks++;
    if (cyc < 0 || kp.o_press_vld !== 1'b0) begin
      n_fail++; $display("FAIL wrap_release11: got cycle %0d press %b expected release alone", cyc, kp.o_press_vld);
    end
    tick();
    n_checks++;
    if (kp.o_press_vld !== 1'b1 || kp.o_key_code !== 4'd0) begin
      n_fail++; $display("FAIL wrap_press0: got press %b code %0d expected 1 0", kp.o_press_vld, kp.o_key_code);
    end
    kp.i_key_in[0] = 1'b0;
    wait_pulse(1'b0, 20, cyc, other);
    n_checks++;
    if (cyc < 0) begin n_fail++; $display("FAIL wrap_release0: got %0d expected a release", cyc); end
  endtask

  task automatic test_reset_mid_hold();
    int cyc, other;
    kp.i_key_in[6] = 1'b1;
    wait_pulse(1'b1, 30, cyc, other);
    n_checks++;
    if (cyc < 0 || kp.o_key_code !== 4'd6) begin
      n_fail++; $display("FAIL hold6_press: got cycle %0d code %0d expected code 6", cyc, kp.o_key_code);
    end
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_vec() !== 9'd0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %b expected %b", out_vec(), 9'd0);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    wait_pulse(1'b1, 40, cyc, other);
    n_checks++;
    if (cyc !== 7 || kp.o_key_code !== 4'd6) begin
      n_fail++; $display("FAIL redetect6: got cycle %0d code %0d expected cycle 7 code 6", cyc, kp.o_key_code);
    end
    n_checks++;
    if (other !== 0) begin n_fail++; $display("FAIL reset_no_release: got %0d expected 0", other); end
    kp.i_key_in[6] = 1'b0;
    wait_pulse(1'b0, 20, cyc, other);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_manual_press();
    test_glitch();
    test_sel_err();
    test_scan_priority();
    test_scan_wrap();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
